// File: rtl/tap_delay_line.sv
// Stall-capable delay line with two muxed taps, per-stage valid
// tracking and an occupancy counter.
module tap_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  input  logic [SEL_W-1:0] sel1,
  input  logic [SEL_W-1:0] sel2,
  output logic [WIDTH-1:0] out1,
  output logic             out1_valid,
  output logic [WIDTH-1:0] out2,
  output logic             out2_valid,
  output logic [SEL_W:0]   fill_cnt,
  output logic             full
);

  localparam logic [SEL_W:0] DEPTH_C = (SEL_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [SEL_W:0]   r_cnt;

  logic [WIDTH-1:0] w_in;
  logic [SEL_W:0]   w_cnt_nxt;

  // Invalid samples carry zero data so idle taps read clean zeros.
  assign w_in = in_valid ? in : '0;

  assign w_cnt_nxt = r_cnt
                   + (SEL_W+1)'(in_valid)
                   - (SEL_W+1)'(r_vld[DEPTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++)
        r_data[k] <= '0;
      r_vld <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++)
        r_data[k] <= '0;
      r_vld <= '0;
      r_cnt <= '0;
    end else if (en) begin
      r_data[0] <= w_in;
      for (int k = 1; k < DEPTH; k++)
        r_data[k] <= r_data[k-1];
      r_vld <= {r_vld[DEPTH-2:0], in_valid};
      r_cnt <= w_cnt_nxt;
    end
  end

  // Out-of-range selects fall through to the zero defaults.
  always_comb begin
    out1       = '0;
    out1_valid = 1'b0;
    out2       = '0;
    out2_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sel1 == SEL_W'(k)) begin
        out1       = r_data[k];
        out1_valid = r_vld[k];
      end
      if (sel2 == SEL_W'(k)) begin
        out2       = r_data[k];
        out2_valid = r_vld[k];
      end
    end
  end

  assign fill_cnt = r_cnt;
  assign full     = (r_cnt == DEPTH_C);

endmodule

// File: tb/tb_tap_delay_line.sv
// Randomised bench for tap_delay_line: queue model checked every
// cycle on two depths, plus hand-computed scenario checks.
module tb_tap_delay_line;

  localparam int W = 4;
  localparam int S = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, flush, in_valid;
  logic [W-1:0] din;
  logic [S-1:0] sel1, sel2;

  logic [W-1:0] a_o1, a_o2, b_o1, b_o2;
  logic         a_v1, a_v2, b_v1, b_v2;
  logic [S:0]   a_cnt, b_cnt;
  logic         a_full, b_full;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  tap_delay_line #(.WIDTH(W), .DEPTH(8), .SEL_W(S)) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in(din), .sel1(sel1), .sel2(sel2),
    .out1(a_o1), .out1_valid(a_v1), .out2(a_o2), .out2_valid(a_v2),
    .fill_cnt(a_cnt), .full(a_full)
  );

  tap_delay_line #(.WIDTH(W), .DEPTH(6), .SEL_W(S)) dut6 (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
    .in_valid(in_valid), .in(din), .sel1(sel1), .sel2(sel2),
    .out1(b_o1), .out1_valid(b_v1), .out2(b_o2), .out2_valid(b_v2),
    .fill_cnt(b_cnt), .full(b_full)
  );

  // Model: newest sample at index 0, each entry {valid, data}.
  logic [W:0] q8[$];
  logic [W:0] q6[$];

  function automatic void mclear();
    q8 = {};
    q6 = {};
    for (int i = 0; i < 8; i++) q8.push_back('0);
    for (int i = 0; i < 6; i++) q6.push_back('0);
  endfunction

  function automatic logic [W:0] mtap(input logic [W:0] q[$], input int s);
    if (s >= q.size()) return '0;
    return q[s];
  endfunction

  function automatic int mcnt(input logic [W:0] q[$]);
    int n = 0;
    foreach (q[i]) if (q[i][W]) n++;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mclear();
    end else if (flush) begin
      mclear();
    end else if (en) begin
      q8.push_front({in_valid, in_valid ? din : 4'd0});
      q6.push_front({in_valid, in_valid ? din : 4'd0});
      void'(q8.pop_back());
      void'(q6.pop_back());
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("d8 tap1", {a_v1, a_o1}, mtap(q8, int'(sel1)));
      chk("d8 tap2", {a_v2, a_o2}, mtap(q8, int'(sel2)));
      chk("d8 cnt", a_cnt, mcnt(q8));
      chk("d8 full", a_full, mcnt(q8) == 8);
      chk("d6 tap1", {b_v1, b_o1}, mtap(q6, int'(sel1)));
      chk("d6 tap2", {b_v2, b_o2}, mtap(q6, int'(sel2)));
      chk("d6 cnt", b_cnt, mcnt(q6));
      chk("d6 full", b_full, mcnt(q6) == 6);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic v, input logic [W-1:0] d);
    en = 1'b1; flush = 1'b0; in_valid = v; din = d;
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0;
    din = '0; sel1 = 3'd0; sel2 = 3'd1;
    mclear();
    #1;
    chk("rst out1", {a_v1, a_o1}, 0);
    chk("rst cnt", a_cnt, 0);
    @(posedge clk);
    started = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Basic: out1 is 1 edge late, out2 is 2 edges late
    push(1, 2);
    chk("b1 out1", {a_v1, a_o1}, 5'h12);
    chk("b1 out2v", a_v2, 0);
    chk("b1 cnt", a_cnt, 1);
    push(1, 3);
    chk("b2 out1", a_o1, 3);
    chk("b2 out2", a_o2, 2);
    push(1, 1);
    chk("b3 out1", a_o1, 1);
    chk("b3 out2", a_o2, 3);
    chk("b3 cnt", a_cnt, 3);

    // Stall with in changing
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = W'($urandom);
      in_valid = 1'(i);
      tick();
      chk("stall out1", a_o1, 1);
      chk("stall out2", a_o2, 3);
      chk("stall cnt", a_cnt, 3);
    end
    push(1, 4);
    chk("res out1", a_o1, 4);
    chk("res out2", a_o2, 1);
    push(1, 2);
    chk("res2 out1", a_o1, 2);
    chk("res2 out2", a_o2, 4);
    chk("res2 cnt", a_cnt, 5);

    // Fill and overflow
    do_flush();
    for (int i = 1; i <= 8; i++) push(1, W'(i));
    sel1 = 3'd7;
    #1;
    chk("fill full", a_full, 1);
    chk("fill cnt", a_cnt, 8);
    chk("fill out1", a_o1, 1);
    chk("d6 fill cnt", b_cnt, 6);
    push(1, 9);
    chk("ovf cnt", a_cnt, 8);
    chk("ovf out1", a_o1, 2);
    chk("ovf full", a_full, 1);

    // Bubbles
    do_flush();
    sel1 = 3'd0; sel2 = 3'd1;
    for (int i = 0; i < 6; i++) begin
      push(1'((i + 1) % 2), 5);
      chk("bub out1", {a_v1, a_o1}, (i % 2 == 0) ? 5'h15 : 5'h00);
      chk("bub out2", {a_v2, a_o2}, (i % 2 == 1) ? 5'h15 : 5'h00);
      chk("bub cnt", a_cnt, i / 2 + 1);
    end
    sel2 = 3'd7;
    #1;
    chk("oor d6 out2", {b_v2, b_o2}, 0);

    // Flush beats en with a valid sample
    do_flush();
    for (int i = 1; i <= 4; i++) push(1, W'(i));
    flush = 1'b1; en = 1'b1; in_valid = 1'b1; din = 9;
    tick();
    flush = 1'b0; en = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel1 = 3'(s);
      #1;
      chk("flush tap", {a_v1, a_o1}, 0);
    end
    chk("flush cnt", a_cnt, 0);
    chk("flush full", a_full, 0);
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 39) == 0);
      in_valid = 1'($urandom);
      din = W'($urandom);
      sel1 = 3'($urandom);
      sel2 = 3'($urandom);
      tick();
    end

    // Async reset between edges with the line full
    flush = 1'b0;
    for (int i = 1; i <= 8; i++) push(1, W'(i + 3));
    sel1 = 3'd0; sel2 = 3'd5;
    #1 rst_n = 1'b0;
    #1;
    chk("arst out1", {a_v1, a_o1}, 0);
    chk("arst out2", {a_v2, a_o2}, 0);
    chk("arst cnt", a_cnt, 0);
    chk("arst full", a_full, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      en = 1'($urandom);
      in_valid = 1'($urandom);
      din = W'($urandom);
      sel1 = 3'($urandom);
      sel2 = 3'($urandom);
      tick();
    end

    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
